// File: rtl/fp_div_rsp_buffer_pkg.sv
// Shared FPU definitions used by the divide response buffer and its NaN
// canonicaliser: FP32 field widths, the canonical quiet NaN, and the
// per-lane exception flag layout {NV,DZ,OF,UF,NX}.
package fp_div_rsp_buffer_pkg;

    localparam int unsigned FP32_W      = 32;
    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_MANT_W = 23;

    localparam logic [FP32_W-1:0] CANON_NAN = 32'h7FC00000;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int unsigned FFLAGS_W = $bits(fflags_t);

endpackage

// File: rtl/fp_div_rsp_buffer_nan_canon.sv
// fp_nan_canon: combinational FP32 NaN canonicaliser for one lane.
// Any NaN (exponent all ones, mantissa non-zero) becomes the canonical quiet
// NaN; infinities, zeros, normals and subnormals pass through unchanged.
// Ports:
//   raw_in     in  32  raw single-precision value
//   canon_out  out 32  canonicalised value
module fp_nan_canon
    import fp_div_rsp_buffer_pkg::*;
(
    input  logic [FP32_W-1:0] raw_in,
    output logic [FP32_W-1:0] canon_out
);

    logic [FP32_EXP_W-1:0]  exp_f;
    logic [FP32_MANT_W-1:0] mant_f;

    assign exp_f  = raw_in[FP32_MANT_W +: FP32_EXP_W];
    assign mant_f = raw_in[FP32_MANT_W-1:0];

    always_comb begin
        canon_out = raw_in;
        if ((&exp_f) && (|mant_f)) begin
            canon_out = CANON_NAN;
        end
    end

endmodule

// File: rtl/fp_div_rsp_buffer.sv
// fp_div_rsp_buffer: in-order response buffer downstream of the FP divider.
// Absorbs divider results while the FPU arbiter back-pressures, canonicalises
// NaN lanes on write, and presents the oldest entry at the head.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_in / ready_in        divider response handshake (ready_in = ~full)
//   tag_in, result_in          response tag, LANES x 32-bit raw quotients
//   has_fflags_in, fflags_in   flag-valid bit, LANES x 5-bit fflags
//   valid_out / ready_out      arbiter handshake (valid_out = ~empty)
//   tag_out, result_out,
//   has_fflags_out, fflags_out head entry, all zero while empty
//   count                      occupied entries
// Optional (macro FP_RSP_BUF_PERF_EN):
//   perf_stall_cycles          cycles with valid_out & ~ready_out
//   perf_full_cycles           cycles with the buffer full
module fp_div_rsp_buffer
    import fp_div_rsp_buffer_pkg::*;
#(
    parameter int unsigned TAGW  = 1,
    parameter int unsigned LANES = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [TAGW-1:0]               tag_in,
    input  logic [LANES*FP32_W-1:0]       result_in,
    input  logic                          has_fflags_in,
    input  logic [LANES*FFLAGS_W-1:0]     fflags_in,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [TAGW-1:0]               tag_out,
    output logic [LANES*FP32_W-1:0]       result_out,
    output logic                          has_fflags_out,
    output logic [LANES*FFLAGS_W-1:0]     fflags_out,
    output logic [$clog2(DEPTH):0]        count
`ifdef FP_RSP_BUF_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cycles,
    output logic [31:0]                   perf_full_cycles
`endif
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned PTRW = IDXW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;

    logic [TAGW-1:0]           tag_q    [DEPTH];
    logic [TAGW-1:0]           tag_d    [DEPTH];
    logic [LANES*FP32_W-1:0]   result_q [DEPTH];
    logic [LANES*FP32_W-1:0]   result_d [DEPTH];
    logic                      has_ff_q [DEPTH];
    logic                      has_ff_d [DEPTH];
    logic [LANES*FFLAGS_W-1:0] fflags_q [DEPTH];
    logic [LANES*FFLAGS_W-1:0] fflags_d [DEPTH];

    logic [LANES*FP32_W-1:0] result_canon;
    logic [IDXW-1:0]         wr_idx;
    logic [IDXW-1:0]         rd_idx;
    logic                    empty;
    logic                    full;
    logic                    push;
    logic                    pop;

    for (genvar l = 0; l < LANES; l++) begin : g_canon
        fp_nan_canon u_canon (
            .raw_in    (result_in[l*FP32_W +: FP32_W]),
            .canon_out (result_canon[l*FP32_W +: FP32_W])
        );
    end

    assign wr_idx = wr_ptr_q[IDXW-1:0];
    assign rd_idx = rd_ptr_q[IDXW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDXW] != rd_ptr_q[IDXW]);
    assign push   = valid_in & ready_in;
    assign pop    = valid_out & ready_out;

    assign ready_in  = ~full;
    assign valid_out = ~empty;
    assign count     = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tag_d    = tag_q;
        result_d = result_q;
        has_ff_d = has_ff_q;
        fflags_d = fflags_q;
        if (push) begin
            tag_d[wr_idx]    = tag_in;
            result_d[wr_idx] = result_canon;
            has_ff_d[wr_idx] = has_fflags_in;
            fflags_d[wr_idx] = fflags_in;
            wr_ptr_d         = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                result_q[i] <= '0;
                has_ff_q[i] <= 1'b0;
                fflags_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            has_ff_q <= has_ff_d;
            fflags_q <= fflags_d;
        end
    end

    // Head data is forced to zero while empty so stale entries never leak.
    always_comb begin
        tag_out        = '0;
        result_out     = '0;
        has_fflags_out = 1'b0;
        fflags_out     = '0;
        if (!empty) begin
            tag_out        = tag_q[rd_idx];
            result_out     = result_q[rd_idx];
            has_fflags_out = has_ff_q[rd_idx];
            fflags_out     = fflags_q[rd_idx];
        end
    end

`ifdef FP_RSP_BUF_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_full_q,  perf_full_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_full_d  = perf_full_q;
        if (valid_out && !ready_out) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (full) begin
            perf_full_d = perf_full_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_full_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_full_q  <= perf_full_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_full_cycles  = perf_full_q;
`endif

endmodule

// File: tb/tb_fp_div_rsp_buffer.sv
// Self-checking bench for fp_div_rsp_buffer (TAGW=8, LANES=2, DEPTH=4).
// Accepted responses are queued with their expected (canonicalised) head
// values; a monitor compares every popped head against the queue front.
module tb_fp_div_rsp_buffer;

    localparam int TAGW  = 8;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  valid_in;
    logic                  ready_in;
    logic [TAGW-1:0]       tag_in;
    logic [LANES*32-1:0]   result_in;
    logic                  has_fflags_in;
    logic [LANES*5-1:0]    fflags_in;
    logic                  valid_out;
    logic                  ready_out;
    logic [TAGW-1:0]       tag_out;
    logic [LANES*32-1:0]   result_out;
    logic                  has_fflags_out;
    logic [LANES*5-1:0]    fflags_out;
    logic [CW-1:0]         count;
`ifdef FP_RSP_BUF_PERF_EN
    logic [31:0]           perf_stall_cycles;
    logic [31:0]           perf_full_cycles;
    int unsigned           stall_model = 0;
    int unsigned           full_model  = 0;
`endif

    always #5 clk = ~clk;

    fp_div_rsp_buffer #(
        .TAGW  (TAGW),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .tag_in         (tag_in),
        .result_in      (result_in),
        .has_fflags_in  (has_fflags_in),
        .fflags_in      (fflags_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .tag_out        (tag_out),
        .result_out     (result_out),
        .has_fflags_out (has_fflags_out),
        .fflags_out     (fflags_out),
        .count          (count)
`ifdef FP_RSP_BUF_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_full_cycles  (perf_full_cycles)
`endif
    );

    typedef struct {
        logic [TAGW-1:0]     tag;
        logic [LANES*32-1:0] res;
        logic                hf;
        logic [LANES*5-1:0]  ff;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Reference: any lane whose exponent field is 255 with a non-zero
    // fraction is a NaN and must read back as the canonical quiet NaN.
    function automatic logic [LANES*32-1:0] model_canon(input logic [LANES*32-1:0] raw);
        logic [LANES*32-1:0] r;
        int unsigned v, e, m;
        r = raw;
        for (int l = 0; l < LANES; l++) begin
            v = raw[l*32 +: 32];
            e = (v / (32'd1 << 23)) % 256;
            m = v % (32'd1 << 23);
            if (e == 255 && m != 0) r[l*32 +: 32] = 32'h7FC00000;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_lane();
        logic [31:0] v;
        logic        s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: v = {s, 8'hFF, 23'($urandom_range(1, (1 << 23) - 1))};
            1: v = {s, 8'hFF, 23'h0};
            2: v = {s, 31'h0};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [TAGW-1:0] t);
        valid_in      = 1'b1;
        tag_in        = t;
        for (int l = 0; l < LANES; l++) result_in[l*32 +: 32] = rand_lane();
        has_fflags_in = 1'($urandom_range(0, 1));
        fflags_in     = (LANES*5)'($urandom);
    endtask

    task automatic drain();
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        chk("drain_complete", 128'(exp_q.size()), 128'(0));
    endtask

    // Record accepted responses just after the negedge; inputs are stable
    // until the following posedge, where the push takes effect.
    always @(negedge clk) begin
        rsp_t r;
        #1;
        if (!reset && valid_in && ready_in) begin
            r.tag = tag_in;
            r.res = model_canon(result_in);
            r.hf  = has_fflags_in;
            r.ff  = fflags_in;
            exp_q.push_back(r);
        end
    end

    // Monitor: occupancy/handshake status and head contents on every cycle.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            chk("count", 128'(count), 128'(exp_q.size()));
            chk("valid_out", 128'(valid_out), 128'(exp_q.size() != 0));
            chk("ready_in", 128'(ready_in), 128'(exp_q.size() != DEPTH));
`ifdef FP_RSP_BUF_PERF_EN
            chk("perf_stall", 128'(perf_stall_cycles), 128'(stall_model));
            chk("perf_full", 128'(perf_full_cycles), 128'(full_model));
            if (exp_q.size() != 0 && !ready_out) stall_model++;
            if (exp_q.size() == DEPTH) full_model++;
`endif
            if (!valid_out) begin
                chk("empty_data_zero",
                    128'({tag_out, result_out, has_fflags_out, fflags_out}), 128'(0));
            end else if (ready_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop_tag", 128'(tag_out), 128'('1));
                end else begin
                    e = exp_q.pop_front();
                    chk("head_tag", 128'(tag_out), 128'(e.tag));
                    chk("head_result", 128'(result_out), 128'(e.res));
                    chk("head_has_fflags", 128'(has_fflags_out), 128'(e.hf));
                    chk("head_fflags", 128'(fflags_out), 128'(e.ff));
                end
            end
        end else begin
`ifdef FP_RSP_BUF_PERF_EN
            stall_model = 0;
            full_model  = 0;
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d entries outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        valid_in      = 1'b0;
        ready_out     = 1'b0;
        tag_in        = '0;
        result_in     = '0;
        has_fflags_in = 1'b0;
        fflags_in     = '0;
        step();
        step();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid_out", 128'(valid_out), 128'(0));
            chk("idle_ready_in", 128'(ready_in), 128'(1));
            chk("idle_count", 128'(count), 128'(0));
            chk("idle_result_out", 128'(result_out), 128'(0));
        end
        step();

        // Fill to DEPTH with the arbiter stalled; a 5th response must wait.
        ready_out = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            drive(TAGW'(t));
            step();
        end
        drive(TAGW'(5));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_count", 128'(count), 128'(4));
            chk("full_ready_in", 128'(ready_in), 128'(0));
            chk("full_head_tag", 128'(tag_out), 128'(1));
            step();
        end
        valid_in = 1'b0;
        drain();
        @(negedge clk);
        chk("after_drain_ready_in", 128'(ready_in), 128'(1));
        step();

        // Per-lane NaN canonicalisation: lane0 signalling NaN, lane1 +inf.
        ready_out     = 1'b0;
        valid_in      = 1'b1;
        tag_in        = 8'h33;
        result_in     = {32'h7F800000, 32'h7F800001};
        has_fflags_in = 1'b1;
        fflags_in     = 10'b10000_00001;
        step();
        valid_in = 1'b0;
        @(negedge clk);
        chk("nan_lane0", 128'(result_out[31:0]), 128'(32'h7FC00000));
        chk("nan_lane1", 128'(result_out[63:32]), 128'(32'h7F800000));
        chk("nan_fflags", 128'(fflags_out), 128'(10'b10000_00001));
        step();
        drain();

        // Single occupant with push and pop every cycle.
        ready_out = 1'b0;
        drive(8'h40);
        step();
        ready_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(TAGW'(8'h41 + i));
            step();
            @(negedge clk);
            chk("pp_valid_out", 128'(valid_out), 128'(1));
            chk("pp_count", 128'(count), 128'(1));
        end
        step();
        drain();

        // Reset with three entries held; inputs during reset are ignored.
        ready_out = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drive(TAGW'(8'hA1 + t));
            step();
        end
        drive(8'hEE);
        reset = 1'b1;
        exp_q.delete();
        step();
        reset    = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        step();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) drive(TAGW'($urandom));
            else valid_in = 1'b0;
            ready_out = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

`ifdef FP_RSP_BUF_PERF_EN
        // Seven stalled cycles with a valid head.
        reset = 1'b1;
        exp_q.delete();
        step();
        reset     = 1'b0;
        ready_out = 1'b0;
        drive(8'h77);
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        @(negedge clk);
        chk("perf_stall_7", 128'(perf_stall_cycles), 128'(7));
        step();
        drain();
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
